lap_stopwatch: RTL and testbench

Parametrised multi-digit stopwatch with a multiplexed 7-segment driver, debounced start/stop, clear and lap (split) buttons, and selectable wrap or saturate overflow. It sits directly between the board push-buttons and the 7-segment/anode pins. It replaces fixed-width ad-hoc counter chains with one configurable BCD/base-6 digit chain.

---
 rtl/lap_stopwatch_pkg.sv | 31 +++
 rtl/lap_stopwatch_btn_conditioner.sv | 55 +++++
 rtl/lap_stopwatch.sv | 155 +++++++++++++++
 tb/tb_lap_stopwatch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lap_stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: digit width, per-index radix limit
// and the 7-segment decoder.
package lap_stopwatch_pkg;

   localparam int unsigned DIGIT_W = 4;

   // Even digits count 0..9, odd digits count 0..5.
   function automatic logic [DIGIT_W-1:0] digit_max(input int unsigned idx);
      return (idx % 2 == 0) ? DIGIT_W'(9) : DIGIT_W'(5);
   endfunction

   // {g,f,e,d,c,b,a}, active high; anything outside 0..9 is blank.
   function automatic logic [6:0] seg_decode(input logic [DIGIT_W-1:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/lap_stopwatch_btn_conditioner.sv
// Push-button conditioner: 2-FF synchroniser, stability filter and a one-cycle
// pulse on each accepted rising level.
module lap_stopwatch_btn_conditioner #(
   parameter int unsigned DEBOUNCE = 65536
) (
   input  logic clk0,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int unsigned CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Accept a new level once it has differed from the current one DEBOUNCE times in a row.
   always_comb begin
      sync1_d = btn;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
         level_d = sync2_q;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/lap_stopwatch.sv
// Multi-digit stopwatch with lap freeze, wrap/saturate overflow and a
// multiplexed 7-segment driver.
module lap_stopwatch #(
   parameter int unsigned          DIGITS   = 4,
   parameter int unsigned          TICK_DIV = 50000,
   parameter int unsigned          SCAN_DIV = 262144,
   parameter int unsigned          DEBOUNCE = 65536,
   parameter int unsigned          SAT_MODE = 0,
   parameter logic [DIGITS-1:0]    DP_MASK  = DIGITS'(4'b0100)
) (
   input  logic              clk0,
   input  logic              rst_n,
   input  logic              btn_start,
   input  logic              btn_clear,
   input  logic              btn_lap,
   output logic [7:0]        seg7,
   output logic [DIGITS-1:0] line,
   output logic              running,
   output logic              lap_active,
   output logic              overflow
);

   import lap_stopwatch_pkg::*;

   localparam int unsigned PRE_W = $clog2(TICK_DIV);
   localparam int unsigned SCN_W = $clog2(SCAN_DIV);
   localparam int unsigned IDX_W = $clog2(DIGITS);

   logic start_p, clear_p, lap_p;

   logic [PRE_W-1:0]                presc_q, presc_d;
   logic [SCN_W-1:0]                scan_cnt_q, scan_cnt_d;
   logic [IDX_W-1:0]                scan_idx_q, scan_idx_d;
   logic [DIGITS-1:0][DIGIT_W-1:0]  dig_q, dig_d;
   logic [DIGITS-1:0][DIGIT_W-1:0]  lap_q, lap_d;
   logic [DIGITS-1:0][DIGIT_W-1:0]  disp_c;
   logic                            running_q, running_d;
   logic                            lap_active_q, lap_active_d;
   logic                            overflow_q, overflow_d;
   logic [DIGITS-1:0]               line_q, line_d;
   logic [7:0]                      seg_q, seg_d;
   logic                            tick_c, clear_c, start_c, carry_c;

   lap_stopwatch_btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_start (
      .clk0(clk0), .rst_n(rst_n), .btn(btn_start), .press(start_p));
   lap_stopwatch_btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_clear (
      .clk0(clk0), .rst_n(rst_n), .btn(btn_clear), .press(clear_p));
   lap_stopwatch_btn_conditioner #(.DEBOUNCE(DEBOUNCE)) u_btn_lap (
      .clk0(clk0), .rst_n(rst_n), .btn(btn_lap), .press(lap_p));

   // Prescaler, digit ripple, lap capture and control flags; clear has final say.
   always_comb begin
      presc_d      = presc_q;
      dig_d        = dig_q;
      lap_d        = lap_q;
      running_d    = running_q;
      lap_active_d = lap_active_q;
      overflow_d   = overflow_q;
      carry_c      = 1'b0;
      clear_c      = clear_p & ~running_q;
      start_c      = start_p & ~clear_p;
      tick_c       = running_q && (presc_q == PRE_W'(TICK_DIV - 1));

      if (start_c) running_d = ~running_q;

      if (running_q) presc_d = tick_c ? '0 : presc_q + PRE_W'(1);

      if (tick_c) begin
         carry_c = 1'b1;
         for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry_c) begin
               if (dig_q[i] == digit_max(i)) begin
                  dig_d[i] = '0;
               end else begin
                  dig_d[i] = dig_q[i] + DIGIT_W'(1);
                  carry_c  = 1'b0;
               end
            end
         end
         // Carry out of the top digit means every digit was at its maximum.
         if (carry_c) begin
            overflow_d = 1'b1;
            if (SAT_MODE != 0) begin
               dig_d     = dig_q;
               running_d = 1'b0;
            end
         end
      end

      if (lap_p) begin
         if (lap_active_q) begin
            lap_active_d = 1'b0;
         end else if (running_q) begin
            lap_d        = dig_q;
            lap_active_d = 1'b1;
         end
      end

      if (clear_c) begin
         dig_d        = '0;
         presc_d      = '0;
         overflow_d   = 1'b0;
         lap_active_d = 1'b0;
      end
   end

   assign disp_c = lap_active_q ? lap_q : dig_q;

   // Scan: line and segments load together at each slot boundary.
   always_comb begin
      scan_cnt_d = scan_cnt_q + SCN_W'(1);
      scan_idx_d = scan_idx_q;
      line_d     = line_q;
      seg_d      = seg_q;
      if (scan_cnt_q == SCN_W'(SCAN_DIV - 1)) begin
         scan_cnt_d = '0;
         scan_idx_d = (scan_idx_q == IDX_W'(DIGITS - 1)) ? '0 : scan_idx_q + IDX_W'(1);
         line_d     = DIGITS'(1) << scan_idx_d;
         seg_d      = {DP_MASK[scan_idx_d], seg_decode(disp_c[scan_idx_d])};
      end
   end

   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         scan_cnt_q   <= '0;
         scan_idx_q   <= '0;
         dig_q        <= '0;
         lap_q        <= '0;
         running_q    <= 1'b0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
         line_q       <= DIGITS'(1);
         seg_q        <= 8'h00;
      end else begin
         presc_q      <= presc_d;
         scan_cnt_q   <= scan_cnt_d;
         scan_idx_q   <= scan_idx_d;
         dig_q        <= dig_d;
         lap_q        <= lap_d;
         running_q    <= running_d;
         lap_active_q <= lap_active_d;
         overflow_q   <= overflow_d;
         line_q       <= line_d;
         seg_q        <= seg_d;
      end
   end

   assign seg7       = seg_q;
   assign line       = line_q;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch: a wrap and a saturate instance share the buttons and
// are compared every cycle against a seconds-count reference model.
module tb_lap_stopwatch;

   localparam int unsigned DIGITS   = 4;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned SCAN_DIV = 2;
   localparam int unsigned DEBOUNCE = 3;
   localparam int          NVAL     = 3600;
   localparam logic [3:0]  DPM      = 4'b0100;

   logic       clk0 = 1'b0;
   logic       rst_n, btn_start, btn_clear, btn_lap;
   logic [7:0] seg7_w, seg7_s;
   logic [3:0] line_w, line_s;
   logic       run_w, run_s, lap_w, lap_s, ovf_w, ovf_s;

   lap_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                   .DEBOUNCE(DEBOUNCE), .SAT_MODE(0), .DP_MASK(DPM)) u_wrap (
      .clk0(clk0), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
      .btn_lap(btn_lap), .seg7(seg7_w), .line(line_w), .running(run_w),
      .lap_active(lap_w), .overflow(ovf_w));

   lap_stopwatch #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV),
                   .DEBOUNCE(DEBOUNCE), .SAT_MODE(1), .DP_MASK(DPM)) u_sat (
      .clk0(clk0), .rst_n(rst_n), .btn_start(btn_start), .btn_clear(btn_clear),
      .btn_lap(btn_lap), .seg7(seg7_s), .line(line_s), .running(run_s),
      .lap_active(lap_s), .overflow(ovf_s));

   always #5 clk0 = ~clk0;

   // Reference state, index 0 = wrap instance, 1 = saturate instance.
   int         m_val[2], m_presc[2], m_lapval[2];
   bit         m_run[2], m_lap[2], m_ovf[2];
   logic [7:0] m_seg[2];
   int         cyc;
   int         sched_edge;
   logic [2:0] sched_mask;
   int         n_pass = 0, n_total = 0, n_fail = 0;

   function automatic logic [6:0] pattern(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;  default: return 7'h00;
      endcase
   endfunction

   // Digit i of a seconds-style count with alternating base 10 / base 6 places.
   function automatic int digit_of(input int v, input int i);
      int div = 1;
      for (int k = 0; k < i; k++) div = div * ((k % 2 == 0) ? 10 : 6);
      return (v / div) % ((i % 2 == 0) ? 10 : 6);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         m_val[s] = 0; m_presc[s] = 0; m_lapval[s] = 0;
         m_run[s] = 0; m_lap[s] = 0; m_ovf[s] = 0; m_seg[s] = 8'h00;
      end
      cyc = 0;
      sched_edge = -1;
      sched_mask = 3'b000;
   endtask

   task automatic model_edge();
      logic [2:0] p;
      bit run0, tick, clr, stt, nrun;
      int idx, disp;
      logic [3:0] dpm;
      dpm = DPM;
      p = (cyc == sched_edge) ? sched_mask : 3'b000;
      for (int s = 0; s < 2; s++) begin
         if (cyc % SCAN_DIV == 0) begin
            idx  = (cyc / SCAN_DIV) % DIGITS;
            disp = m_lap[s] ? m_lapval[s] : m_val[s];
            m_seg[s] = {dpm[idx], pattern(digit_of(disp, idx))};
         end
         run0 = m_run[s];
         tick = run0 && (m_presc[s] == TICK_DIV - 1);
         clr  = p[1] && !run0;
         stt  = p[0] && !p[1];
         nrun = run0 ^ stt;
         if (p[2]) begin
            if (m_lap[s]) m_lap[s] = 0;
            else if (run0) begin m_lap[s] = 1; m_lapval[s] = m_val[s]; end
         end
         if (run0) begin
            m_presc[s] = tick ? 0 : m_presc[s] + 1;
            if (tick) begin
               if (m_val[s] == NVAL - 1) begin
                  m_ovf[s] = 1;
                  if (s == 1) nrun = 0;
                  else m_val[s] = 0;
               end else begin
                  m_val[s] = m_val[s] + 1;
               end
            end
         end
         if (clr) begin
            m_val[s] = 0; m_presc[s] = 0; m_ovf[s] = 0; m_lap[s] = 0;
         end
         m_run[s] = nrun;
      end
   endtask

   task automatic check_all();
      logic [3:0] exp_line;
      exp_line = 4'b0001 << ((cyc / SCAN_DIV) % DIGITS);
      check("wrap.line", line_w, exp_line);
      check("wrap.seg7", seg7_w, m_seg[0]);
      check("wrap.running", run_w, m_run[0]);
      check("wrap.lap_active", lap_w, m_lap[0]);
      check("wrap.overflow", ovf_w, m_ovf[0]);
      check("sat.line", line_s, exp_line);
      check("sat.seg7", seg7_s, m_seg[1]);
      check("sat.running", run_s, m_run[1]);
      check("sat.lap_active", lap_s, m_lap[1]);
      check("sat.overflow", ovf_s, m_ovf[1]);
   endtask

   task automatic step();
      @(posedge clk0);
      cyc++;
      model_edge();
      #1;
      check_all();
   endtask

   // mask = {lap, clear, start}; a hold of DEBOUNCE or more samples is accepted
   // and acts on the edge DEBOUNCE+3 after the raw rise.
   task automatic press(input logic [2:0] mask, input int hold, input int gap);
      {btn_lap, btn_clear, btn_start} = mask;
      if (hold >= DEBOUNCE) begin
         sched_edge = cyc + DEBOUNCE + 3;
         sched_mask = mask;
      end
      repeat (hold) step();
      {btn_lap, btn_clear, btn_start} = 3'b000;
      repeat (gap) step();
   endtask

   task automatic run_until(input int target, input int limit);
      int n = 0;
      while (m_val[0] != target && n < limit) begin
         step();
         n++;
      end
      if (n >= limit) begin
         n_total++;
         n_fail++;
         $error("FAIL run_until observed=%0d expected=%0d cycle=%0d", m_val[0], target, cyc);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(negedge clk0);
      rst_n = 1'b1;
      #1;
      check_all();
   endtask

   initial begin
      {btn_lap, btn_clear, btn_start} = 3'b000;
      do_reset();

      // Short glitch must not register; then a clean 5-cycle press starts counting.
      btn_start = 1'b1;
      repeat (2) step();
      btn_start = 1'b0;
      repeat (10) step();
      press(3'b001, 5, 8);
      run_until(60, 400);

      // Stop, clear, restart, lap freeze and release.
      press(3'b001, 4, 8);
      press(3'b010, 4, 8);
      press(3'b001, 4, 8);
      run_until(7, 200);
      press(3'b100, 4, 8);
      repeat (12 * TICK_DIV) step();
      press(3'b100, 4, 8);
      repeat (20) step();

      // Clear while running is ignored; then stop and clear.
      press(3'b010, 4, 8);
      repeat (20) step();
      press(3'b001, 4, 8);
      repeat (9) step();
      press(3'b010, 4, 8);

      // Simultaneous presses: clear beats start, lap sees pre-toggle running.
      press(3'b011, 4, 8);
      press(3'b101, 4, 12);
      press(3'b101, 4, 12);
      press(3'b100, 4, 8);

      // Random button traffic.
      for (int i = 0; i < 40; i++) begin
         press(3'($urandom_range(1, 7)), int'($urandom_range(DEBOUNCE, DEBOUNCE + 4)),
               int'($urandom_range(DEBOUNCE + 4, 40)));
      end

      // Overflow: wrap instance rolls to 00:00, saturate instance stops at 59:59.
      if (m_lap[0]) press(3'b100, 4, 8);
      if (!m_run[0]) press(3'b001, 4, 8);
      run_until(NVAL - 1, 20000);
      repeat (3 * TICK_DIV + 16) step();

      // Asynchronous reset between clock edges.
      @(posedge clk0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async.seg7", seg7_w, 8'h00);
      check("async.line", line_w, 4'b0001);
      check("async.running", run_w, 1'b0);
      check("async.overflow", ovf_w, 1'b0);
      check("async.sat_overflow", ovf_s, 1'b0);
      check("async.sat_seg7", seg7_s, 8'h00);
      do_reset();
      press(3'b001, 4, 8);
      repeat (20) step();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
